// File: rtl/chess_kbd_pkg.sv
// chess_kbd_pkg: square/move types, mailbox addresses and reader FSM states
// shared by the keyboard front end, the move reader and the move validator.
package chess_kbd_pkg;
    typedef logic [5:0] square_t;
    typedef struct packed {
        square_t from;
        square_t to;
    } move_t;
    localparam logic [11:0] KBD_SRC_ADDR = 12'd64;
    localparam logic [11:0] KBD_DST_ADDR = 12'd65;
    typedef enum logic [1:0] {IDLE, HAVE_SRC, HAVE_DST, COMMIT} kbd_rd_state_t;
endpackage

// File: rtl/move_fifo.sv
// move_fifo: synchronous FIFO of move_t.
// A push is accepted when the FIFO is full if a pop happens in the same cycle.
module move_fifo
    import chess_kbd_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  push,
    input  move_t push_data,
    input  logic  pop,
    output move_t head,
    output logic  full,
    output logic  empty
);
    localparam int AW = $clog2(DEPTH);
    move_t          mem [DEPTH];
    logic  [AW:0]   wr_ptr, rd_ptr;
    logic  [AW:0]   count;
    logic           do_push, do_pop;
    always_comb begin
        count   = wr_ptr - rd_ptr;
        full    = count == (AW+1)'(DEPTH);
        empty   = count == '0;
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head    = mem[rd_ptr[AW-1:0]];
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/keyboard_move_reader.sv
// keyboard_move_reader: snoops mailbox writes, pairs source/destination squares
// into moves and queues them for a valid/ready consumer. KBD_MOVE_TIMEOUT_EN adds a partial-move timeout.
module keyboard_move_reader
    import chess_kbd_pkg::*;
#(
    parameter logic [11:0] SRC_ADDR       = KBD_SRC_ADDR,
    parameter logic [11:0] DST_ADDR       = KBD_DST_ADDR,
    parameter int          FIFO_DEPTH     = 2,
    parameter int          TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [11:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        move_valid,
    input  logic        move_ready,
    output logic [5:0]  move_from,
    output logic [5:0]  move_to,
    output logic [1:0]  pending,
    output logic        overflow,
    input  logic        ovf_clear,
    output logic        timeout
);
    kbd_rd_state_t state, state_next, from_idle;
    square_t       src_q, dst_q;
    move_t         head;
    logic          accepted, is_src, is_dst, fifo_full, fifo_empty, push, pop, expire;
    always_comb begin
        accepted = wr_en && (wr_addr == SRC_ADDR || wr_addr == DST_ADDR) && wr_data[31:6] == '0;
        is_src   = accepted && wr_addr == SRC_ADDR;
        is_dst   = accepted && wr_addr == DST_ADDR;
    end
`ifdef KBD_MOVE_TIMEOUT_EN
    logic [25:0] age;
    logic        timeout_q;
    assign expire  = (state == HAVE_SRC || state == HAVE_DST) && !accepted
                     && age == 26'(TIMEOUT_CYCLES - 1);
    assign timeout = timeout_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            age       <= '0;
            timeout_q <= 1'b0;
        end else begin
            age       <= (accepted || !(state == HAVE_SRC || state == HAVE_DST)) ? '0 : age + 1'b1;
            timeout_q <= expire;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            if (is_src) src_q <= wr_data[5:0];
            if (is_dst) dst_q <= wr_data[5:0];
            overflow <= (push && fifo_full && !pop) || (overflow && !ovf_clear);
        end
    end
    always_comb begin
        from_idle  = is_src ? HAVE_SRC : is_dst ? HAVE_DST : IDLE;
        state_next = expire ? IDLE :
                     state == HAVE_SRC ? (is_dst ? COMMIT : HAVE_SRC) :
                     state == HAVE_DST ? (is_src ? COMMIT : HAVE_DST) : from_idle;
    end
    always_comb begin
        pending    = state == HAVE_SRC ? 2'b01 : state == HAVE_DST ? 2'b10 : 2'b00;
        push       = state == COMMIT;
        move_valid = !fifo_empty;
        pop        = move_valid && move_ready;
        move_from  = head.from;
        move_to    = head.to;
    end
    move_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_data('{from: src_q, to: dst_q}),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );
endmodule

// File: tb/tb_keyboard_move_reader.sv
// tb_keyboard_move_reader: directed bench for the keyboard move reader; run with
// KBD_MOVE_TIMEOUT_EN defined to cover the timeout path.
module tb_keyboard_move_reader;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [11:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        move_ready = 1'b0;
    logic        ovf_clear = 1'b0;
    logic        move_valid, overflow, timeout;
    logic [5:0]  move_from, move_to;
    logic [1:0]  pending;
    int          tests = 0;
    int          fails = 0;

    keyboard_move_reader #(.FIFO_DEPTH(2), .TIMEOUT_CYCLES(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .move_valid(move_valid),
        .move_ready(move_ready),
        .move_from (move_from),
        .move_to   (move_to),
        .pending   (pending),
        .overflow  (overflow),
        .ovf_clear (ovf_clear),
        .timeout   (timeout)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write(input logic [11:0] a, input logic [31:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pop_one();
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if ({move_valid, move_from, move_to, pending, overflow, timeout} !== 17'd0) begin
            fails++;
            $display("FAIL reset_outputs got v=%b f=%h t=%h p=%b o=%b to=%b want all 0",
                     move_valid, move_from, move_to, pending, overflow, timeout);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_move();
        move_ready = 1'b1;
        write(12'd64, 32'o12);
        tests++;
        if (pending !== 2'b01) begin fails++; $display("FAIL basic_pending_src got %b want 01", pending); end
        write(12'd65, 32'o32);
        tests++;
        if (move_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_early got %b want 0", move_valid); end
        tick();
        tests++;
        if ({move_valid, move_from, move_to} !== {1'b1, 6'h0A, 6'h1A}) begin
            fails++;
            $display("FAIL basic_move got v=%b f=%h t=%h want v=1 f=0a t=1a", move_valid, move_from, move_to);
        end
        tick();
        move_ready = 1'b0;
        tests++;
        if (move_valid !== 1'b0) begin fails++; $display("FAIL basic_popped got %b want 0", move_valid); end
    endtask

    task automatic test_latest_src();
        write(12'd64, 32'h00);
        write(12'd64, 32'h07);
        write(12'd65, 32'h3F);
        tick();
        tests++;
        if ({move_valid, move_from, move_to, pending} !== {1'b1, 6'h07, 6'h3F, 2'b00}) begin
            fails++;
            $display("FAIL latest_src got v=%b f=%h t=%h p=%b want v=1 f=07 t=3f p=00",
                     move_valid, move_from, move_to, pending);
        end
        pop_one();
        tests++;
        if (move_valid !== 1'b0) begin fails++; $display("FAIL latest_src_single got %b want 0", move_valid); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            write(12'd64, 32'(2 * i + 1));
            write(12'd65, 32'(2 * i + 2));
            tick();
            tests++;
            if ({move_valid, move_from, move_to} !== {1'b1, 6'h01, 6'h02}) begin
                fails++;
                $display("FAIL ovf_head_stable[%0d] got v=%b f=%h t=%h want v=1 f=01 t=02",
                         i, move_valid, move_from, move_to);
            end
            tests++;
            if (overflow !== (i == 2)) begin
                fails++;
                $display("FAIL ovf_flag[%0d] got %b want %b", i, overflow, i == 2);
            end
        end
        pop_one();
        tests++;
        if ({move_valid, move_from, move_to} !== {1'b1, 6'h03, 6'h04}) begin
            fails++;
            $display("FAIL ovf_second got v=%b f=%h t=%h want v=1 f=03 t=04", move_valid, move_from, move_to);
        end
        pop_one();
        tests++;
        if (move_valid !== 1'b0) begin fails++; $display("FAIL ovf_third_dropped got %b want 0", move_valid); end
        tests++;
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b want 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        write(12'd64, 32'h11);
        write(12'd65, 32'h12);
        write(12'd65, 32'h14);
        write(12'd64, 32'h13);
        write(12'd64, 32'h15);
        write(12'd65, 32'h16);
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
        tests++;
        if ({overflow, move_valid, move_from, move_to} !== {1'b0, 1'b1, 6'h13, 6'h14}) begin
            fails++;
            $display("FAIL full_push_pop got o=%b v=%b f=%h t=%h want o=0 v=1 f=13 t=14",
                     overflow, move_valid, move_from, move_to);
        end
        pop_one();
        tests++;
        if ({move_valid, move_from, move_to} !== {1'b1, 6'h15, 6'h16}) begin
            fails++;
            $display("FAIL full_order got v=%b f=%h t=%h want v=1 f=15 t=16", move_valid, move_from, move_to);
        end
        pop_one();
        tests++;
        if (move_valid !== 1'b0) begin fails++; $display("FAIL full_drained got %b want 0", move_valid); end
    endtask

    task automatic test_ignored_and_reset();
        write(12'd66, 32'h01);
        write(12'd64, 32'h40);
        write(12'd65, 32'h80);
        tests++;
        if ({pending, move_valid} !== 3'b000) begin
            fails++;
            $display("FAIL ignored_writes got p=%b v=%b want p=00 v=0", pending, move_valid);
        end
        write(12'd64, 32'h21);
        write(12'd65, 32'h22);
        write(12'd64, 32'h05);
        tests++;
        if ({pending, move_valid} !== 3'b011) begin
            fails++;
            $display("FAIL pre_reset got p=%b v=%b want p=01 v=1", pending, move_valid);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({move_valid, move_from, move_to, pending, overflow, timeout} !== 17'd0) begin
            fails++;
            $display("FAIL async_reset got v=%b f=%h t=%h p=%b o=%b want all 0",
                     move_valid, move_from, move_to, pending, overflow);
        end
        reset = 1'b1;
        tick();
        write(12'd65, 32'h09);
        tests++;
        if ({pending, move_valid} !== 3'b100) begin
            fails++;
            $display("FAIL after_reset got p=%b v=%b want p=10 v=0", pending, move_valid);
        end
        write(12'd64, 32'h08);
        tick();
        pop_one();
    endtask

`ifdef KBD_MOVE_TIMEOUT_EN
    task automatic test_timeout();
        int seen = 0;
        write(12'd64, 32'h09);
        for (int i = 1; i <= 24 && seen == 0; i++) begin
            tick();
            if (timeout === 1'b1) seen = i;
        end
        tests++;
        if (seen != 16) begin fails++; $display("FAIL timeout_cycle got %0d want 16", seen); end
        tests++;
        if (pending !== 2'b00) begin fails++; $display("FAIL timeout_pending got %b want 00", pending); end
        tick();
        tests++;
        if (timeout !== 1'b0) begin fails++; $display("FAIL timeout_pulse_width got %b want 0", timeout); end
        write(12'd65, 32'h11);
        tick();
        tests++;
        if ({pending, move_valid} !== 3'b100) begin
            fails++;
            $display("FAIL timeout_then_dst got p=%b v=%b want p=10 v=0", pending, move_valid);
        end
    endtask
`else
    task automatic test_timeout();
        int seen = 0;
        write(12'd64, 32'h09);
        for (int i = 0; i < 24; i++) begin
            tick();
            if (timeout !== 1'b0) seen++;
        end
        tests++;
        if (seen != 0 || pending !== 2'b01) begin
            fails++;
            $display("FAIL no_timeout got pulses=%0d p=%b want pulses=0 p=01", seen, pending);
        end
        write(12'd65, 32'h11);
        tick();
        tests++;
        if ({move_valid, move_from, move_to} !== {1'b1, 6'h09, 6'h11}) begin
            fails++;
            $display("FAIL persist_move got v=%b f=%h t=%h want v=1 f=09 t=11", move_valid, move_from, move_to);
        end
        pop_one();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_move();
        test_latest_src();
        test_overflow();
        test_full_push_pop();
        test_ignored_and_reset();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
